// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Bridges the core's memory-stage request to a word-addressed data memory.
//   Byte, halfword and word loads/stores at byte addresses become word-index
//   accesses. Sub-word stores use read-modify-write, because the memory only
//   accepts full-word writes. Loads are sign- or zero-extended. Misaligned,
//   oversize and out-of-range requests are rejected with an error response and
//   never reach memory.
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst           synchronous active-high reset
//   i_req_valid     request present
//   o_req_ready     unit can accept a request (IDLE only)
//   i_req_we        1 = store, 0 = load
//   i_req_size      00 byte, 01 half, 10 word, 11 illegal
//   i_req_unsigned  load zero-extends when 1, sign-extends when 0
//   i_req_addr      byte address
//   i_req_wdata     store data, right-aligned for byte/half
//   o_resp_valid    one-cycle completion pulse
//   o_resp_rdata    extended load data; 0 for stores and errors
//   o_resp_err      request rejected (valid with o_resp_valid)
//   o_mem_addr      word index {2'b00, addr[31:2]}, 0 while idle
//   o_mem_wdata     word written to memory
//   o_mem_we        memory write enable, one cycle per store
//   i_mem_rd        combinational memory read data
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rd
);

    localparam logic [1:0]  SizeByte  = 2'b00;
    localparam logic [1:0]  SizeHalf  = 2'b01;
    localparam logic [1:0]  SizeWord  = 2'b10;
    localparam logic [31:0] MemWordsW = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StResp  = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Registered copy of the accepted request; later states never look at i_req_*.
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_old_word;   // word captured in READ, base for the RMW merge
    logic [31:0] r_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_req_err;
    logic        w_addr_oor;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic        w_enter_resp;

    // -----------------------------------------------------------------------
    // Request checking on the live inputs (only meaningful when accepting)
    // -----------------------------------------------------------------------
    assign w_accept   = (r_state == StIdle) && i_req_valid;
    assign w_addr_oor = ({2'b00, i_req_addr[31:2]} >= MemWordsW);

    always_comb begin
        w_req_err = w_addr_oor;
        unique case (i_req_size)
            SizeByte: ;
            SizeHalf: if (i_req_addr[0])         w_req_err = 1'b1;
            SizeWord: if (i_req_addr[1:0] != 0)  w_req_err = 1'b1;
            default:  w_req_err = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Load lane select and extension from the word being read
    // -----------------------------------------------------------------------
    always_comb begin
        w_rd_byte = 8'h00;
        w_rd_half = 16'h0000;
        unique case (r_addr[1:0])
            2'd0: w_rd_byte = i_mem_rd[7:0];
            2'd1: w_rd_byte = i_mem_rd[15:8];
            2'd2: w_rd_byte = i_mem_rd[23:16];
            default: w_rd_byte = i_mem_rd[31:24];
        endcase
        w_rd_half = r_addr[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];

        w_load_ext = i_mem_rd;
        if (r_size == SizeByte) begin
            w_load_ext = {{24{w_rd_byte[7] & ~r_unsigned}}, w_rd_byte};
        end else if (r_size == SizeHalf) begin
            w_load_ext = {{16{w_rd_half[15] & ~r_unsigned}}, w_rd_half};
        end
    end

    // -----------------------------------------------------------------------
    // Store merge: only the addressed lane of the old word is replaced
    // -----------------------------------------------------------------------
    always_comb begin
        w_merged = r_old_word;
        if (r_size == SizeWord) begin
            w_merged = r_wdata;
        end else if (r_size == SizeHalf) begin
            if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
        end else begin
            unique case (r_addr[1:0])
                2'd0: w_merged[7:0]   = r_wdata[7:0];
                2'd1: w_merged[15:8]  = r_wdata[7:0];
                2'd2: w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    if (w_req_err) begin
                        w_state_next = StResp;
                    end else if (i_req_we && (i_req_size == SizeWord)) begin
                        w_state_next = StWrite;
                    end else begin
                        w_state_next = StRead;
                    end
                end
            end
            StRead:  w_state_next = r_we ? StWrite : StResp;
            StWrite: w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Response data/err only change on the edge into RESP so they hold between responses.
    assign w_enter_resp = (w_state_next == StResp) && (r_state != StResp);

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        o_req_ready  = (r_state == StIdle);
        o_resp_valid = (r_state == StResp);
        o_mem_we     = (r_state == StWrite);
        o_mem_addr   = 32'h0;
        o_mem_wdata  = 32'h0;
        if (r_state != StIdle) begin
            o_mem_addr = {2'b00, r_addr[31:2]};
        end
        if (r_state == StWrite) begin
            o_mem_wdata = w_merged;
        end
    end

    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_resp_err;

    // -----------------------------------------------------------------------
    // State and data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_old_word <= 32'h0;
            r_rdata    <= 32'h0;
            r_resp_err <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_we       <= i_req_we;
                r_size     <= i_req_size;
                r_unsigned <= i_req_unsigned;
                r_addr     <= i_req_addr;
                r_wdata    <= i_req_wdata;
            end

            if (r_state == StRead) begin
                r_old_word <= i_mem_rd;
            end

            if (w_enter_resp) begin
                r_resp_err <= (r_state == StIdle);
                r_rdata    <= ((r_state == StRead) && !r_we) ? w_load_ext : 32'h0;
            end
        end
    end

endmodule
